// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and GF(2^8) helpers for the AES round datapath.
//   aes_state_t : 128-bit state, column-major (byte k = state[127-8k -: 8])
//   aes_col_t   : one 32-bit column, row 0 in the most significant byte
//   aes_byte_t  : one state byte
//   sm_state_t  : control FSM states of shift_mix_unit
//   xtime()     : multiply by x (0x02) modulo x^8+x^4+x^3+x+1
// ---------------------------------------------------------------------------
package aes_pkg;

   typedef logic [127:0] aes_state_t;
   typedef logic [31:0]  aes_col_t;
   typedef logic [7:0]   aes_byte_t;

   // Low byte of the reduction polynomial 0x11B; bit 8 is implicit in xtime.
   localparam aes_byte_t AES_POLY = 8'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MIX  = 2'd1,
      HOLD = 2'd2
   } sm_state_t;

   function automatic aes_byte_t xtime(input aes_byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/mix_column.sv
// ---------------------------------------------------------------------------
// mix_column
// Combinational AES MixColumns on a single column.
//   col_i : input column  {a0, a1, a2, a3}, a0 = row 0
//   col_o : output column {b0, b1, b2, b3}
// b_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4, over GF(2^8).
// ---------------------------------------------------------------------------
module mix_column
   import aes_pkg::*;
(
   input  logic [31:0] col_i,
   output logic [31:0] col_o
);

   aes_byte_t a [4];
   aes_byte_t b [4];

   for (genvar r = 0; r < 4; r++) begin : g_row
      assign a[r] = col_i[31-8*r -: 8];
      // 3*x is computed as xtime(x) ^ x, so the whole row is plain XOR.
      assign b[r] = xtime(a[r])
                  ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                  ^ a[(r+2)%4]
                  ^ a[(r+3)%4];
      assign col_o[31-8*r -: 8] = b[r];
   end

endmodule

// File: rtl/shift_mix_unit.sv
// ---------------------------------------------------------------------------
// shift_mix_unit
// AES round stage between SubBytes and AddRoundKey: ShiftRows on capture,
// then MixColumns over 4/COLS_PER_CYCLE cycles, result held on a
// valid/ready output. final_round skips MixColumns (last AES round).
//   clk, n_rst          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_ready is combinational
//   in_data, final_round: SubBytes state and last-round qualifier
//   out_valid/out_ready : output handshake; out_data is the state register
//   busy                : FSM is not IDLE
// COLS_PER_CYCLE must be 1, 2 or 4.
// ---------------------------------------------------------------------------
module shift_mix_unit
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
)(
   input  logic         clk,
   input  logic         n_rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         final_round,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int         MIX_CYCLES = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] LAST_CNT   = 2'(MIX_CYCLES - 1);

   sm_state_t  st_q, st_d;
   aes_state_t state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       final_q, final_d;

   // ShiftRows: row r of the output takes row r of column (c+r) mod 4.
   aes_state_t shifted;
   for (genvar c = 0; c < 4; c++) begin : g_sr_col
      for (genvar r = 0; r < 4; r++) begin : g_sr_row
         assign shifted[127-8*(4*c+r) -: 8] = in_data[127-8*(4*((c+r)%4)+r) -: 8];
      end
   end

   // Column view of the state register, column 0 first.
   aes_col_t cols_q [4];
   for (genvar c = 0; c < 4; c++) begin : g_cols
      assign cols_q[c] = state_q[127-32*c -: 32];
   end

   // One mix_column per lane; lane g works on column cnt*COLS_PER_CYCLE+g.
   logic [1:0] grp_col [COLS_PER_CYCLE];
   aes_col_t   mix_out [COLS_PER_CYCLE];
   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
      assign grp_col[g] = 2'(cnt_q * COLS_PER_CYCLE + g);
      mix_column u_mix_column (
         .col_i (cols_q[grp_col[g]]),
         .col_o (mix_out[g])
      );
   end

   // State with the current group of columns replaced by their mixed value.
   aes_col_t   mixed_cols [4];
   aes_state_t mixed_state;
   always_comb begin
      mixed_cols = cols_q;
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
         mixed_cols[grp_col[g]] = mix_out[g];
      end
   end
   assign mixed_state = {mixed_cols[0], mixed_cols[1], mixed_cols[2], mixed_cols[3]};

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      st_d     = st_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      final_d  = final_q;
      in_ready = 1'b0;

      case (st_q)
         IDLE: in_ready = 1'b1;
         MIX: begin
            // Last-round states never enter MIX; the guard keeps them unmixed regardless.
            if (!final_q) state_d = mixed_state;
            if (cnt_q == LAST_CNT) begin
               st_d  = HOLD;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         HOLD: begin
            // Handoff: a new state may enter in the same cycle the old one leaves.
            in_ready = out_ready;
            if (out_ready) st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase

      if (in_valid && in_ready) begin
         state_d = shifted;
         final_d = final_round;
         cnt_d   = '0;
         st_d    = final_round ? HOLD : MIX;
      end
   end

   // NOTE: the state register is reset (not left uninitialised) because out_data must read 0 out of reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         st_q    <= IDLE;
         state_q <= '0;
         cnt_q   <= '0;
         final_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         st_q    <= st_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         final_q <= final_d;
      end
   end

   assign out_valid = (st_q == HOLD);
   assign out_data  = state_q;
   assign busy      = (st_q != IDLE);

endmodule
